// File: rtl/pterm_engine.sv
// Programmable product-term engine: registered literals, per-term hold qualification, handshaked config.
// Optional sticky event capture is compiled in with `define PTERM_STICKY_EN.
module pterm_engine #(
  parameter int unsigned N_IN   = 5,
  parameter int unsigned N_TERM = 6,
  parameter int unsigned HOLD_W = 4,
  localparam int unsigned IDX_W = (N_TERM > 1) ? $clog2(N_TERM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IN-1:0]   in_vec,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [N_IN-1:0]   cfg_care,
  input  logic [N_IN-1:0]   cfg_val,
  input  logic [HOLD_W-1:0] cfg_hold,
  output logic              cfg_ready,
  output logic [N_TERM-1:0] term_out,
  output logic              any_out,
  output logic [N_TERM-1:0] sticky,
  input  logic              sticky_clr
);

  typedef enum logic {CFG_BUSY = 1'b0, CFG_IDLE = 1'b1} cfg_state_e;

  localparam logic [HOLD_W-1:0] CNT_MAX = '1;

  cfg_state_e cfg_state_q, cfg_state_d;
  logic       wr_acc;

  logic [N_IN-1:0]                in_q;
  logic [N_TERM-1:0][N_IN-1:0]    care_q, care_d, val_q, val_d;
  logic [N_TERM-1:0][HOLD_W-1:0]  hold_q, hold_d, cnt_q, cnt_d;
  logic [N_TERM-1:0]              match, term_q, term_d;
  logic                           any_q, any_d;

  // Config handshake: one busy cycle after every accepted write.
  always_comb begin
    cfg_state_d = cfg_state_q;
    wr_acc      = 1'b0;
    case (cfg_state_q)
      CFG_IDLE: begin
        if (cfg_we) begin
          wr_acc      = 1'b1;
          cfg_state_d = CFG_BUSY;
        end
      end
      CFG_BUSY: cfg_state_d = CFG_IDLE;
      default:  cfg_state_d = CFG_IDLE;
    endcase
  end

  // Term match, hold counting and config update; a write to a term overrides its normal update.
  always_comb begin
    care_d = care_q;
    val_d  = val_q;
    hold_d = hold_q;
    match  = '0;
    cnt_d  = '0;
    term_d = '0;
    for (int i = 0; i < int'(N_TERM); i++) begin
      match[i] = (care_q[i] != '0) && (((in_q ^ val_q[i]) & care_q[i]) == '0);
      if (!match[i])
        cnt_d[i] = '0;
      else if (cnt_q[i] == CNT_MAX)
        cnt_d[i] = cnt_q[i];
      else
        cnt_d[i] = cnt_q[i] + HOLD_W'(1);
      term_d[i] = match[i] && (cnt_q[i] >= hold_q[i]);
      if (wr_acc && (int'(cfg_idx) == i)) begin
        care_d[i] = cfg_care;
        val_d[i]  = cfg_val;
        hold_d[i] = cfg_hold;
        cnt_d[i]  = '0;
        term_d[i] = 1'b0;
      end
    end
    any_d = |term_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_state_q <= CFG_IDLE;
      in_q        <= '0;
      care_q      <= '0;
      val_q       <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      term_q      <= '0;
      any_q       <= 1'b0;
    end else begin
      cfg_state_q <= cfg_state_d;
      in_q        <= in_vec;
      care_q      <= care_d;
      val_q       <= val_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      term_q      <= term_d;
      any_q       <= any_d;
    end
  end

`ifdef PTERM_STICKY_EN
  logic [N_TERM-1:0] sticky_q, sticky_d;

  // Rising term edges set their bit; a set beats a coincident clear.
  always_comb begin
    sticky_d = (sticky_q & ~{N_TERM{sticky_clr}}) | (term_d & ~term_q);
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign sticky = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky            = '0;
`endif

  assign cfg_ready = (cfg_state_q == CFG_IDLE);
  assign term_out  = term_q;
  assign any_out   = any_q;

endmodule

// File: tb/tb_pterm_engine.sv
// Scoreboard bench for pterm_engine: stimulus queues per-edge expectations, a negedge monitor checks them.
module tb_pterm_engine;

  localparam int unsigned N_IN   = 5;
  localparam int unsigned N_TERM = 6;
  localparam int unsigned HOLD_W = 4;
  localparam int unsigned IDX_W  = 3;
`ifdef PTERM_STICKY_EN
  localparam bit STK_EN = 1'b1;
`else
  localparam bit STK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N_IN-1:0]   in_vec;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [N_IN-1:0]   cfg_care;
  logic [N_IN-1:0]   cfg_val;
  logic [HOLD_W-1:0] cfg_hold;
  logic              cfg_ready;
  logic [N_TERM-1:0] term_out;
  logic              any_out;
  logic [N_TERM-1:0] sticky;
  logic              sticky_clr;

  pterm_engine #(.N_IN(N_IN), .N_TERM(N_TERM), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_care(cfg_care), .cfg_val(cfg_val), .cfg_hold(cfg_hold), .cfg_ready(cfg_ready),
    .term_out(term_out), .any_out(any_out), .sticky(sticky), .sticky_clr(sticky_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    logic [N_TERM-1:0] term;
    logic              any;
    logic [N_TERM-1:0] stk;
    logic              rdy;
    string             name;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Monitor: after each edge, compare DUT outputs against the entry queued for that edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
      e = sb.pop_front();
      n_chk++;
      if (e.cyc < edge_n) begin
        $display("FAIL %s: expectation for edge %0d never checked (now %0d)", e.name, e.cyc, edge_n);
      end else if ({term_out, any_out, sticky, cfg_ready} === {e.term, e.any, e.stk, e.rdy}) begin
        n_pass++;
      end else begin
        $display("FAIL %s @edge %0d: got term=%h any=%b sticky=%h ready=%b, want term=%h any=%b sticky=%h ready=%b",
                 e.name, edge_n, term_out, any_out, sticky, cfg_ready, e.term, e.any, e.stk, e.rdy);
      end
    end
  end

  // Queue the expected outputs after the coming edge, then advance one cycle.
  task automatic step(input logic [N_TERM-1:0] t, input logic [N_TERM-1:0] s,
                      input logic r, input string nm);
    exp_t e;
    e.cyc  = edge_n + 1;
    e.term = t;
    e.any  = |t;
    e.stk  = s & {N_TERM{STK_EN}};
    e.rdy  = r;
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [IDX_W-1:0] idx, input logic [N_IN-1:0] care,
                    input logic [N_IN-1:0] val, input logic [HOLD_W-1:0] hold);
    cfg_we   = 1'b1;
    cfg_idx  = idx;
    cfg_care = care;
    cfg_val  = val;
    cfg_hold = hold;
  endtask

  initial begin
    rst = 1'b1; sticky_clr = 1'b1; in_vec = 5'h1F;
    wr(3'd0, 5'h1F, 5'h1F, 4'd0);
    step(6'h00, 6'h00, 1'b1, "reset_a");
    step(6'h00, 6'h00, 1'b1, "reset_b");
    rst = 1'b0; cfg_we = 1'b0; sticky_clr = 1'b0;
    repeat (3) step(6'h00, 6'h00, 1'b1, "unprogrammed");

    // Single term, hold 0
    wr(3'd0, 5'h1B, 5'h1A, 4'd0);
    step(6'h00, 6'h00, 1'b0, "wr0_busy");
    cfg_we = 1'b0; in_vec = 5'h1A;
    step(6'h00, 6'h00, 1'b1, "t0_lat");
    step(6'h01, 6'h01, 1'b1, "t0_rise");
    in_vec = 5'h1B;
    step(6'h01, 6'h01, 1'b1, "t0_fall_lat");
    step(6'h00, 6'h01, 1'b1, "t0_fall");
    in_vec = 5'h1E;
    step(6'h00, 6'h01, 1'b1, "t0_dc_lat");
    step(6'h01, 6'h01, 1'b1, "t0_dontcare");
    in_vec = 5'h00;
    step(6'h01, 6'h01, 1'b1, "t0_off_lat");
    step(6'h00, 6'h01, 1'b1, "t0_off");
    sticky_clr = 1'b1;
    step(6'h00, 6'h00, 1'b1, "stk_clr");
    sticky_clr = 1'b0;

    // Hold 3 on term 5
    wr(3'd5, 5'h15, 5'h11, 4'd3);
    step(6'h00, 6'h00, 1'b0, "wr5_busy");
    cfg_we = 1'b0; in_vec = 5'h11;
    repeat (3) step(6'h00, 6'h00, 1'b1, "hold_short");
    in_vec = 5'h00;
    repeat (2) step(6'h00, 6'h00, 1'b1, "hold_short_off");
    in_vec = 5'h11;
    repeat (4) step(6'h00, 6'h00, 1'b1, "hold_wait");
    step(6'h20, 6'h20, 1'b1, "hold_rise");
    step(6'h20, 6'h20, 1'b1, "hold_stay");
    in_vec = 5'h00;
    step(6'h20, 6'h20, 1'b1, "hold_fall_lat");
    step(6'h00, 6'h20, 1'b1, "hold_fall");

    // Handshake: we held 3 cycles, middle write must be ignored
    wr(3'd2, 5'h01, 5'h01, 4'd0);
    step(6'h00, 6'h20, 1'b0, "hs_1");
    wr(3'd2, 5'h02, 5'h02, 4'd0);
    step(6'h00, 6'h20, 1'b1, "hs_2");
    wr(3'd2, 5'h04, 5'h04, 4'd0);
    step(6'h00, 6'h20, 1'b0, "hs_3");
    cfg_we = 1'b0;
    step(6'h00, 6'h20, 1'b1, "hs_4");
    in_vec = 5'h02;
    step(6'h00, 6'h20, 1'b1, "hs_ign_lat");
    step(6'h00, 6'h20, 1'b1, "hs_ignored");
    in_vec = 5'h04;
    step(6'h00, 6'h20, 1'b1, "hs_acc_lat");
    step(6'h04, 6'h24, 1'b1, "hs_accepted");

    // Out-of-range index: ready drops, no term touched
    wr(3'd7, 5'h1F, 5'h00, 4'd0);
    step(6'h04, 6'h24, 1'b0, "bad_idx_busy");
    cfg_we = 1'b0;
    step(6'h04, 6'h24, 1'b1, "bad_idx_keep");
    in_vec = 5'h00;
    step(6'h04, 6'h24, 1'b1, "bad_idx_lat");
    step(6'h00, 6'h24, 1'b1, "bad_idx_none");
    step(6'h00, 6'h24, 1'b1, "bad_idx_none2");

    // Reprogram an active term; clear coincides with the requalifying rise
    in_vec = 5'h04;
    step(6'h00, 6'h24, 1'b1, "re_lat");
    step(6'h04, 6'h24, 1'b1, "re_active");
    wr(3'd2, 5'h04, 5'h04, 4'd2);
    step(6'h00, 6'h24, 1'b0, "re_clear");
    cfg_we = 1'b0;
    step(6'h00, 6'h24, 1'b1, "re_wait1");
    step(6'h00, 6'h24, 1'b1, "re_wait2");
    sticky_clr = 1'b1;
    step(6'h04, 6'h04, 1'b1, "re_rise_clr");
    sticky_clr = 1'b0;
    in_vec = 5'h1A;
    step(6'h04, 6'h04, 1'b1, "t0_intact_lat");
    step(6'h01, 6'h05, 1'b1, "t0_intact");

    // Reset mid-run with term 5 count at 2 and a coincident write
    in_vec = 5'h11;
    step(6'h01, 6'h05, 1'b1, "pre_rst_lat");
    step(6'h00, 6'h05, 1'b1, "pre_rst_cnt1");
    step(6'h00, 6'h05, 1'b1, "pre_rst_cnt2");
    rst = 1'b1;
    wr(3'd0, 5'h1F, 5'h00, 4'd0);
    step(6'h00, 6'h00, 1'b1, "rst_mid");
    rst = 1'b0; cfg_we = 1'b0;
    repeat (6) step(6'h00, 6'h00, 1'b1, "rst_dead");
    in_vec = 5'h00;
    repeat (3) step(6'h00, 6'h00, 1'b1, "rst_wr_discarded");

    // Maximum hold: counter must saturate, not wrap
    wr(3'd1, 5'h01, 5'h01, 4'd15);
    step(6'h00, 6'h00, 1'b0, "wr1_busy");
    cfg_we = 1'b0; in_vec = 5'h01;
    repeat (16) step(6'h00, 6'h00, 1'b1, "sat_wait");
    step(6'h02, 6'h02, 1'b1, "sat_rise");
    repeat (4) step(6'h02, 6'h02, 1'b1, "sat_hold");
    in_vec = 5'h00;
    step(6'h02, 6'h02, 1'b1, "sat_fall_lat");
    step(6'h00, 6'h02, 1'b1, "sat_fall");
    sticky_clr = 1'b1;
    step(6'h00, 6'h00, 1'b1, "sat_stk_clr");
    sticky_clr = 1'b0;
    step(6'h00, 6'h00, 1'b1, "idle_end");

    @(negedge clk);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      $display("FAIL %s: expectation for edge %0d left unchecked", e.name, e.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pterm_engine.md
PTERM_ENGINE -- requirements
Module: pterm_engine

Interface
REQ-001 The block SHALL have parameter N_IN, default 5, giving the input vector width (bit0=X, bit1=Y, bit2=Z, bit3=K, bit4=M).
REQ-002 The block SHALL have parameter N_TERM, default 6, giving the number of programmable product terms.
REQ-003 The block SHALL have parameter HOLD_W, default 4, giving the hold-counter width.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_vec  in  N_IN  raw input literals
- cfg_we  in  1  config write strobe
- cfg_idx  in  clog2(N_TERM)  term index to write
- cfg_care  in  N_IN  literal-used mask
- cfg_val  in  N_IN  required literal polarity (1=true, 0=complemented)
- cfg_hold  in  HOLD_W  extra consecutive-match cycles required
- cfg_ready  out  1  config write accepted when high
- term_out  out  N_TERM  registered qualified term outputs
- any_out  out  1  OR of term_out, registered
- sticky  out  N_TERM  latched term events
- sticky_clr  in  1  clear all sticky bits

Function
REQ-005 The block SHALL register in_vec into in_q every cycle.
REQ-006 match[i] SHALL be 1 iff care[i]!=0 and ((in_q XOR val[i]) AND care[i])==0; a term with care==0 is disabled, so match=0.
REQ-007 cnt[i] SHALL load saturating cnt[i]+1 (max 2^HOLD_W-1) when match[i]=1, and 0 otherwise.
REQ-008 term_out[i] SHALL be registered as match[i] AND (cnt[i] >= hold[i]); with hold=H, term_out rises on the edge H+2 after in_vec first presents a match held steadily.
REQ-009 term_out[i] SHALL fall on the second edge after in_vec stops matching (in_q then match path).
REQ-010 any_out SHALL be registered as the OR of next-state term_out (same cycle as term_out).
REQ-011 A write SHALL be accepted on an edge where cfg_we=1 and cfg_ready=1; care, val and hold of term cfg_idx update at that edge.
REQ-012 After an accepted write, cfg_ready SHALL be 0 for exactly one cycle; cfg_we during that cycle SHALL be ignored.
REQ-013 An accepted write SHALL clear cnt[cfg_idx] and term_out[cfg_idx] at the same edge; other terms SHALL be unaffected.
REQ-014 A write with cfg_idx >= N_TERM SHALL change no term state but SHALL still drop cfg_ready for one cycle.
REQ-015 Sticky logic (when compiled in) SHALL set sticky[i] on the cycle term_out[i] transitions 0->1; sticky_clr=1 SHALL clear all bits; on a simultaneous set and clear, set SHALL win for that bit.

Reset
REQ-016 On rst=1 at an edge, in_q, care, val, hold, cnt, term_out, any_out and sticky SHALL become 0, and cfg_ready SHALL become 1.
REQ-017 rst SHALL take priority over cfg_we and sticky_clr in the same cycle; a write coinciding with rst SHALL be discarded.
REQ-018 After reset all terms SHALL be disabled, and term_out SHALL remain 0 for any in_vec until programmed.

Configuration
REQ-019 With macro PTERM_STICKY_EN defined, sticky SHALL behave per REQ-015.
REQ-020 Without PTERM_STICKY_EN, sticky SHALL be constant 0, sticky_clr SHALL be ignored, and the port list SHALL be unchanged.

Verification
REQ-021 Single term: write idx0 care=5'h1B val=5'h1A hold=0, then in_vec=5'h1A -> term_out[0]=1 and any_out=1 two edges later; then in_vec=5'h1B -> both 0 two edges later.
REQ-022 Hold: idx5 care=5'h15 val=5'h11 hold=3; in_vec=5'h11 for 3 cycles then 5'h00 -> term_out[5] never rises; 4+ cycles -> rises on edge 5.
REQ-023 Handshake: cfg_we held high for 3 cycles at idx2 -> writes accepted on cycles 1 and 3 only; cfg_ready sequence 1,0,1; cfg_idx=7 -> no term changes.
REQ-024 Reprogram while active: term0 asserted, rewrite idx0 -> term_out[0] is 0 on the next cycle and requalifies per the new hold.
REQ-025 Sticky (PTERM_STICKY_EN): term_out[1] pulses once -> sticky[1]=1 until sticky_clr; clear coincident with a new rise -> sticky[1] stays 1; without the macro -> sticky=0 always.
REQ-026 Reset mid-run: rst during cnt=2 with cfg_we=1 -> all outputs 0, cfg_ready=1, write discarded, term_out stays 0 for any in_vec.
